// File: rtl/cp0.sv
// Coprocessor-0: SR/Cause/EPC/PRId register file plus the interrupt/exception
// arbiter that drives the next-PC selector's intreq and epc inputs.
module cp0 #(
   parameter logic [31:0] PRID = 32'h4D49_5053
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  a1,
   input  logic [4:0]  a2,
   input  logic [31:0] din,
   input  logic        we,
   input  logic [31:0] pc,
   input  logic        bd,
   input  logic [4:0]  exccode,
   input  logic        exlclr,
   input  logic [5:0]  hwint,
   output logic        intreq,
   output logic [31:0] epc,
   output logic [31:0] dout
);

   localparam int unsigned IRQ_W = 6;
   localparam int unsigned EXC_W = 5;
   localparam int unsigned EPC_W = 30;

   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;
   localparam logic [4:0] REG_PRID  = 5'd15;

   // SR fields
   logic [IRQ_W-1:0] im_q, im_d;
   logic             exl_q, exl_d;
   logic             ie_q, ie_d;
   // Cause fields
   logic             bd_q, bd_d;
   logic [IRQ_W-1:0] ip_q, ip_d;
   logic [EXC_W-1:0] exc_code_q, exc_code_d;
   // EPC is word aligned, so only bits 31:2 are stored
   logic [EPC_W-1:0] epc_q, epc_d;

   logic             irq_c;
   logic             exc_c;
   logic [EPC_W-1:0] victim_c;

   // Arbitration: interrupts win over synchronous exceptions; both blocked by EXL.
   always_comb begin
      irq_c    = (|(hwint & im_q)) & ie_q & ~exl_q;
      exc_c    = (exccode != EXC_W'(0)) & ~exl_q;
      victim_c = bd ? (pc[31:2] - EPC_W'(1)) : pc[31:2];
      intreq   = irq_c | exc_c;
   end

   // Next-state for all CP0 fields.
   always_comb begin
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      ip_d       = hwint;
      exc_code_d = exc_code_q;
      epc_d      = epc_q;

      if (intreq) begin
         exl_d      = 1'b1;
         bd_d       = bd;
         epc_d      = victim_c;
         exc_code_d = irq_c ? EXC_W'(0) : exccode;
      end else begin
         if (we) begin
            unique case (a2)
               REG_SR: begin
                  im_d  = din[15:10];
                  exl_d = din[1];
                  ie_d  = din[0];
               end
               REG_EPC: epc_d = din[31:2];
               default: ;
            endcase
         end
         // eret clears EXL even when the same cycle writes SR
         if (exlclr) begin
            exl_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         im_q       <= '0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ip_q       <= '0;
         exc_code_q <= '0;
         epc_q      <= '0;
      end else begin
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         ip_q       <= ip_d;
         exc_code_q <= exc_code_d;
         epc_q      <= epc_d;
      end
   end

   // mfc0 read mux; same-cycle mtc0 data is deliberately not forwarded.
   always_comb begin
      epc = {epc_q, 2'b00};
      unique case (a1)
         REG_SR:    dout = {16'h0000, im_q, 8'h00, exl_q, ie_q};
         REG_CAUSE: dout = {bd_q, 15'h0000, ip_q, 3'b000, exc_code_q, 2'b00};
         REG_EPC:   dout = {epc_q, 2'b00};
         REG_PRID:  dout = PRID;
         default:   dout = 32'h0000_0000;
      endcase
   end

endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0.
module tb_cp0;

   logic        clk;
   logic        rst_n;
   logic [4:0]  a1;
   logic [4:0]  a2;
   logic [31:0] din;
   logic        we;
   logic [31:0] pc;
   logic        bd;
   logic [4:0]  exccode;
   logic        exlclr;
   logic [5:0]  hwint;
   logic        intreq;
   logic [31:0] epc;
   logic [31:0] dout;

   int tests = 0;
   int fails = 0;

   cp0 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a1      (a1),
      .a2      (a2),
      .din     (din),
      .we      (we),
      .pc      (pc),
      .bd      (bd),
      .exccode (exccode),
      .exlclr  (exlclr),
      .hwint   (hwint),
      .intreq  (intreq),
      .epc     (epc),
      .dout    (dout)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
      a1 = addr;
      #1;
      chk(tag, dout, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      a1      = '0;
      a2      = '0;
      din     = '0;
      we      = 1'b0;
      pc      = '0;
      bd      = 1'b0;
      exccode = '0;
      exlclr  = 1'b0;
      hwint   = '0;

      // Reset read-back
      step();
      step();
      chk("rst_intreq", 32'(intreq), 32'h0);
      chk("rst_epc", epc, 32'h0);
      rst_n = 1'b1;
      rd("rst_sr", 5'd12, 32'h0);
      rd("rst_cause", 5'd13, 32'h0);
      rd("rst_epc_rd", 5'd14, 32'h0);
      rd("rst_prid", 5'd15, 32'h4D49_5053);
      step();
      rd("unmapped_rd", 5'd7, 32'h0);

      // Masked interrupt: IP tracks hwint, no request
      hwint = 6'b000100;
      #1;
      chk("masked_intreq", 32'(intreq), 32'h0);
      step();
      rd("masked_cause", 5'd13, 32'h0000_1000);

      // Unmask via mtc0 SR
      we = 1'b1; a2 = 5'd12; din = 32'h0000_1001;
      #1;
      chk("pre_unmask_intreq", 32'(intreq), 32'h0);
      step();
      we = 1'b0; pc = 32'h0000_3010; bd = 1'b0;
      #1;
      chk("unmask_intreq", 32'(intreq), 32'h1);
      rd("unmask_sr", 5'd12, 32'h0000_1001);
      step();
      chk("irq_epc", epc, 32'h0000_3010);
      chk("irq_intreq_drop", 32'(intreq), 32'h0);
      rd("irq_sr", 5'd12, 32'h0000_1003);
      rd("irq_cause", 5'd13, 32'h0000_1000);

      // eret + SR=0 in the same cycle
      hwint = '0; exlclr = 1'b1; we = 1'b1; a2 = 5'd12; din = 32'h0;
      step();
      exlclr = 1'b0; we = 1'b0;
      rd("clear_sr", 5'd12, 32'h0);

      // Delay-slot exception
      exccode = 5'd12; bd = 1'b1; pc = 32'h0000_3024;
      #1;
      chk("ds_intreq", 32'(intreq), 32'h1);
      step();
      exccode = '0; bd = 1'b0;
      chk("ds_epc", epc, 32'h0000_3020);
      rd("ds_cause", 5'd13, 32'h8000_0030);
      chk("ds_intreq_drop", 32'(intreq), 32'h0);

      // Exception while EXL=1 is dropped
      exccode = 5'd10;
      #1;
      chk("nest_intreq", 32'(intreq), 32'h0);
      step();
      exccode = '0;
      chk("nest_epc", epc, 32'h0000_3020);
      rd("nest_cause", 5'd13, 32'h8000_0030);

      // eret with simultaneous SR write: EXL clear wins
      exlclr = 1'b1; we = 1'b1; a2 = 5'd12; din = 32'h0000_0403;
      step();
      exlclr = 1'b0; we = 1'b0;
      rd("eret_sr", 5'd12, 32'h0000_0401);
      chk("eret_intreq", 32'(intreq), 32'h0);

      // Interrupt beats exception; mtc0 EPC discarded
      hwint = 6'b000001; exccode = 5'd4; pc = 32'h0000_3100; bd = 1'b0;
      we = 1'b1; a2 = 5'd14; din = 32'h1234_5678;
      #1;
      chk("prio_intreq", 32'(intreq), 32'h1);
      step();
      we = 1'b0; exccode = '0; hwint = '0;
      chk("prio_epc", epc, 32'h0000_3100);
      rd("prio_cause", 5'd13, 32'h0000_0400);
      rd("prio_sr", 5'd12, 32'h0000_0403);

      // Leave EXL, then EPC alignment
      exlclr = 1'b1;
      step();
      exlclr = 1'b0;
      we = 1'b1; a2 = 5'd14; din = 32'h0000_3007;
      step();
      chk("align_epc", epc, 32'h0000_3004);

      // Cause and PRId are read-only
      a2 = 5'd13; din = 32'hFFFF_FFFF;
      step();
      a2 = 5'd15;
      step();
      we = 1'b0;
      rd("ro_cause", 5'd13, 32'h0);
      rd("ro_prid", 5'd15, 32'h4D49_5053);
      chk("ro_epc", epc, 32'h0000_3004);

      // EPC wrap-around with bd=1, pc=0
      exccode = 5'd1; bd = 1'b1; pc = 32'h0;
      #1;
      chk("wrap_intreq", 32'(intreq), 32'h1);
      step();
      exccode = '0; bd = 1'b0;
      chk("wrap_epc", epc, 32'hFFFF_FFFC);
      rd("wrap_cause", 5'd13, 32'h8000_0004);

      // Asynchronous reset mid-cycle
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_epc", epc, 32'h0);
      chk("async_intreq", 32'(intreq), 32'h0);
      rd("async_sr", 5'd12, 32'h0);
      step();
      rst_n = 1'b1;
      step();
      rd("post_rst_cause", 5'd13, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 register file and exception/interrupt arbiter for the pipelined MIPS core. It holds SR, Cause, EPC and PRId and evaluates hardware interrupts and synchronous exceptions every cycle. It drives the `intreq` and `epc` inputs of the next-PC selector, which redirects fetch to 0x0000_4180 on request and to EPC on `eret`. The block also services `mfc0`/`mtc0` accesses from the memory stage.

## Interface
- PRID, 32'h4D49_5053, constant value returned for register 15 (PRId)
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous reset, active low
- a1  in  5  `mfc0` source register number
- a2  in  5  `mtc0` destination register number
- din  in  32  `mtc0` write data
- we  in  1  `mtc0` write enable
- pc  in  32  PC of the instruction currently in the memory stage (victim PC)
- bd  in  1  memory-stage instruction is in a branch delay slot
- exccode  in  5  synchronous exception code of the memory-stage instruction; 0 = none
- exlclr  in  1  `eret` in the memory stage
- hwint  in  6  external interrupt lines, level-sensitive
- intreq  out  1  take exception/interrupt now (to next-PC selector and pipeline flush)
- epc  out  32  current EPC contents
- dout  out  32  `mfc0` read data

## Operation
- Registers:
  - SR (12): IM = bits 15:10, EXL = bit 1, IE = bit 0; all other bits read 0.
  - Cause (13): BD = bit 31, IP = bits 15:10, ExcCode = bits 6:2; other bits read 0.
  - EPC (14): 32 bits, bits 1:0 always 0.
  - PRId (15): PRID.
- Read path: `dout` is combinational from the current register state. Any other `a1` returns 0. A same-cycle `mtc0` is not forwarded.
- Interrupt condition: `irq = |(hwint & IM) & IE & !EXL`.
- Exception condition: `exc = (exccode != 0) & !EXL`.
- `intreq = irq | exc`, combinational.
- Cause.IP <= hwint on every edge, independent of masking.
- When `intreq=1` at the edge:
  - EXL <= 1
  - BD <= bd
  - EPC <= bd ? {pc[31:2],2'b00} - 4 : {pc[31:2],2'b00}
  - ExcCode <= irq ? 0 : exccode. Interrupt has priority over exception.
  - Any `mtc0` in the same cycle is discarded.
  - `exlclr` is ignored in the same cycle. It cannot coincide in practice, since `intreq` requires EXL=0.
- `mtc0`, applied only when `we=1` and `intreq=0`:
  - a2=12 writes IM, EXL, IE from din[15:10], din[1], din[0].
  - a2=14 writes EPC <= {din[31:2],2'b00}.
  - a2=13, a2=15 and all other numbers are ignored. Cause and PRId are read-only.
- `exlclr=1` with `intreq=0`: EXL <= 0. If `we` also targets SR in the same cycle, the `exlclr` clear of EXL wins; IM and IE still take din.
- Exceptions and interrupts raised while EXL=1 are dropped. They are not latched, though IP keeps tracking `hwint`.

## Timing
- Reset (rst_n low, asynchronous): SR=0, Cause=0, EPC=0. Hence `intreq=0`, `epc=0`, and `dout` is 0 for all `a1` except 15.
- `intreq` has 0-cycle latency from `hwint`, `exccode` or SR changes. SR, EPC and Cause updates are visible on `dout`/`epc` one cycle after the edge.
- `intreq` stays asserted for exactly one cycle per event, because EXL sets at that edge.
- Releasing reset mid-stream: the first edge after rst_n rises is a normal update edge.
- Wrap-around: EPC with bd=1 and pc=0 yields 32'hFFFF_FFFC (modulo-2^32 subtraction).

## Test plan
- Reset read-back:
  - Stimulus: assert rst_n=0 mid-cycle.
  - Response: `epc=0` and `intreq=0` immediately. After release, a1=12/13/14 read 0 and a1=15 reads 32'h4D49_5053.
- Masked then unmasked interrupt:
  - Stimulus: hwint=6'b000100 with SR=0.
  - Response: `intreq=0` and Cause reads 32'h0000_1000. Then `mtc0` SR=32'h0000_1001 → next cycle `intreq=1`.
  - At that edge: with pc=32'h0000_3010, bd=0 → EPC=32'h0000_3010, SR reads 32'h0000_1003, ExcCode=0, `intreq` drops.
- Delay-slot exception:
  - Stimulus: exccode=5'd12, bd=1, pc=32'h0000_3024, SR=0.
  - Response: `intreq=1`. Next cycle EPC=32'h0000_3020 and Cause reads 32'h8000_0030.
- Priority and write-discard:
  - Stimulus: exccode=5'd4 and an enabled interrupt together, plus `we=1`, a2=14, din=32'h1234_5678.
  - Response: ExcCode=0, and EPC is the victim PC, not 32'h1234_5678.
- Eret and nesting:
  - Stimulus: with EXL=1, assert exccode=5'd10 → `intreq=0`, no state change. Then pulse `exlclr` together with `mtc0` SR=32'h0000_0403.
  - Response: SR reads 32'h0000_0401.
- EPC alignment:
  - Stimulus: `mtc0` EPC=32'h0000_3007.
  - Response: `epc=32'h0000_3004` on the next cycle.
